// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner.
//
// Contents:
//   - 2-bit FSM state encodings for the debounce state machine
//   - Default debounce length (stable synchronized samples)
//   - level_for_state(): debounced level implied by a state
package button_pkg;

  // Debounce FSM state encodings
  localparam logic [1:0] StReleased    = 2'd0;
  localparam logic [1:0] StPressWait   = 2'd1;
  localparam logic [1:0] StPressed     = 2'd2;
  localparam logic [1:0] StReleaseWait = 2'd3;

  // Default number of consecutive stable synchronized samples to accept a change
  localparam int unsigned DefaultDebounceCycles = 4;

  // The button counts as down while pressed or while a release is still being
  // qualified, so a bouncing release never glitches the debounced level.
  function automatic logic level_for_state(input logic [1:0] state);
    return (state == StPressed) || (state == StReleaseWait);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//
// Ports:
//   clk - sampling clock
//   rst - synchronous, active-high reset; clears both flops
//   d   - asynchronous input level
//   q   - synchronized level (second flop)
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizes a bouncing button, debounces it with a
// four-state FSM and produces a one-cycle press pulse plus a press counter.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable synchronized samples to accept a change
//                     (1..65535)
//   CNT_W           - debounce counter width, at least clog2(DEBOUNCE_CYCLES)
//
// Ports:
//   clk         - single clock, all state on the rising edge
//   rst         - synchronous, active-high reset
//   btn_raw     - asynchronous, bouncing button level (1 = pressed)
//   b           - registered one-cycle pulse per accepted press
//   btn_level   - registered debounced button level
//   press_count - accepted presses, modulo 256
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       b,
  output logic       btn_level,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             b_q, b_d;
  logic             level_q, level_d;
  logic [7:0]       count_q, count_d;
  logic             accept;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

  // Debounce FSM; cnt only advances while a change is being qualified and
  // stops at CntLast because reaching it always leaves the wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      StReleased: begin
        if (btn_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (!btn_s) begin
          state_d = StReleased;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPressed: begin
        if (!btn_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        // A bounce back to 1 resumes PRESSED without a new pulse.
        if (btn_s) begin
          state_d = StPressed;
        end else if (cnt_q == CntLast) begin
          state_d = StReleased;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // edge that completes the PRESS_WAIT->PRESSED transition.
  always_comb begin
    b_d     = accept;
    level_d = level_for_state(state_d);
    count_d = count_q + {7'd0, accept};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReleased;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      level_q <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      level_q <= level_d;
      count_q <= count_d;
    end
  end

  assign b           = b_q;
  assign btn_level   = level_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner (DEBOUNCE_CYCLES=4 and =1).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       btn1_raw;
  logic       b;
  logic       btn_level;
  logic [7:0] press_count;
  logic       b1;
  logic       btn1_level;
  logic [7:0] press1_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .b           (b),
    .btn_level   (btn_level),
    .press_count (press_count)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES (1),
    .CNT_W           (16)
  ) u_dut1 (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn1_raw),
    .b           (b1),
    .btn_level   (btn1_level),
    .press_count (press1_count)
  );

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    btn_raw  = 1'b0;
    btn1_raw = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int pulses;
  int bad_width;
  int total_pulses;
  int b_seen;
  int level_drop;

  initial begin
    rst      = 1'b1;
    btn_raw  = 1'b0;
    btn1_raw = 1'b0;
    do_reset();
    check_eq("rst_b", int'(b), 0);
    check_eq("rst_level", int'(btn_level), 0);
    check_eq("rst_count", int'(press_count), 0);
    check_eq("rst_b1", int'(b1), 0);

    // Clean press: E0 is the first edge seeing btn_raw=1; b only after E6.
    btn_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq($sformatf("press_b_e%0d", k), int'(b), (k == 6) ? 1 : 0);
      check_eq($sformatf("press_lvl_e%0d", k), int'(btn_level), (k >= 6) ? 1 : 0);
    end
    check_eq("press_count", int'(press_count), 1);
    btn_raw = 1'b0;
    repeat (10) tick();
    check_eq("release_level", int'(btn_level), 0);

    // Short 3-cycle glitch must be rejected.
    do_reset();
    btn_raw = 1'b1;
    b_seen = 0;
    level_drop = 0;
    repeat (3) begin
      tick();
      b_seen += int'(b);
      level_drop += int'(btn_level);
    end
    btn_raw = 1'b0;
    repeat (15) begin
      tick();
      b_seen += int'(b);
      level_drop += int'(btn_level);
    end
    check_eq("glitch_b", b_seen, 0);
    check_eq("glitch_level", level_drop, 0);
    check_eq("glitch_count", int'(press_count), 0);

    // Release bounce of 2 cycles returns to PRESSED without a second pulse.
    do_reset();
    btn_raw = 1'b1;
    repeat (10) tick();
    check_eq("bounce_pre_level", int'(btn_level), 1);
    check_eq("bounce_pre_count", int'(press_count), 1);
    btn_raw = 1'b0;
    b_seen = 0;
    level_drop = 0;
    repeat (2) begin
      tick();
      b_seen += int'(b);
      level_drop += int'(!btn_level);
    end
    btn_raw = 1'b1;
    repeat (15) begin
      tick();
      b_seen += int'(b);
      level_drop += int'(!btn_level);
    end
    check_eq("bounce_b", b_seen, 0);
    check_eq("bounce_level_drop", level_drop, 0);
    check_eq("bounce_count", int'(press_count), 1);

    // 256 clean press/release cycles wrap the counter.
    do_reset();
    bad_width = 0;
    total_pulses = 0;
    for (int p = 0; p < 256; p++) begin
      pulses = 0;
      btn_raw = 1'b1;
      repeat (10) begin
        tick();
        pulses += int'(b);
      end
      btn_raw = 1'b0;
      repeat (10) begin
        tick();
        pulses += int'(b);
      end
      if (pulses != 1) bad_width++;
      total_pulses += pulses;
      if (p == 254) check_eq("wrap_count_255", int'(press_count), 255);
    end
    check_eq("wrap_bad_pulses", bad_width, 0);
    check_eq("wrap_total", total_pulses, 256);
    check_eq("wrap_count", int'(press_count), 0);

    // Reset while PRESSED with the button held: full debounce again.
    do_reset();
    btn_raw = 1'b1;
    repeat (10) tick();
    check_eq("rstp_pre_level", int'(btn_level), 1);
    rst = 1'b1;
    tick();
    check_eq("rstp_b", int'(b), 0);
    check_eq("rstp_level", int'(btn_level), 0);
    check_eq("rstp_count", int'(press_count), 0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("rstp_b_e%0d", k), int'(b), (k == 6) ? 1 : 0);
    end
    check_eq("rstp_count_after", int'(press_count), 1);

    // DEBOUNCE_CYCLES=1: b after E3.
    do_reset();
    btn1_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("dc1_b_e%0d", k), int'(b1), (k == 3) ? 1 : 0);
      check_eq($sformatf("dc1_lvl_e%0d", k), int'(btn1_level), (k >= 3) ? 1 : 0);
    end
    check_eq("dc1_count", int'(press1_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a level change; legal range 1..65535.
REQ-002 SHALL have parameter CNT_W, default 16, debounce counter width; SHALL be at least clog2(DEBOUNCE_CYCLES).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_raw  input  1  asynchronous, bouncing push-button level; 1 = pressed.
REQ-006 SHALL have port b  output  1  one-cycle press pulse that drives the timer controller's b input.
REQ-007 SHALL have port btn_level  output  1  debounced button level.
REQ-008 SHALL have port press_count  output  8  number of accepted presses, modulo 256.

Function
REQ-009 SHALL pass btn_raw through a two-flop synchronizer; the second flop output is btn_s, and the FSM SHALL use only btn_s.
REQ-010 SHALL implement the FSM states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT.
REQ-011 RELEASED: if btn_s=1, SHALL go to PRESS_WAIT and set cnt to 0; otherwise SHALL hold.
REQ-012 PRESS_WAIT: if btn_s=0, SHALL return to RELEASED (bounce rejected); else if cnt==DEBOUNCE_CYCLES-1, SHALL go to PRESSED; else SHALL increment cnt.
REQ-013 PRESSED: if btn_s=0, SHALL go to RELEASE_WAIT and set cnt to 0; otherwise SHALL hold.
REQ-014 RELEASE_WAIT: if btn_s=1, SHALL return to PRESSED with no new pulse; else if cnt==DEBOUNCE_CYCLES-1, SHALL go to RELEASED; else SHALL increment cnt.
REQ-015 b SHALL be registered and SHALL be 1 for exactly one cycle following the PRESS_WAIT->PRESSED transition; otherwise 0.
REQ-016 btn_level SHALL be registered and SHALL be 1 exactly while the state is PRESSED or RELEASE_WAIT.
REQ-017 Latency: with btn_raw steady at 1 from before edge E0, b and btn_level SHALL become 1 after edge E(DEBOUNCE_CYCLES+2), and b SHALL clear after the next edge.
REQ-018 press_count SHALL increment by 1 on the same edge that sets b, and SHALL wrap from 255 to 0.
REQ-019 A held button SHALL produce exactly one pulse; any new pulse SHALL require a full debounced release followed by a full debounced press.
REQ-020 cnt SHALL never exceed DEBOUNCE_CYCLES-1; with DEBOUNCE_CYCLES=1, a single btn_s=1 sample in PRESS_WAIT SHALL be accepted.

Reset
REQ-021 When rst=1 at a rising clk edge, the synchronizer flops, cnt, b, btn_level and press_count SHALL be set to 0, and the state SHALL be set to RELEASED.
REQ-022 rst SHALL take priority over all other inputs.
REQ-023 Reset asserted during PRESS_WAIT, PRESSED or RELEASE_WAIT SHALL discard progress; a button still held after reset SHALL require a full debounce before b fires.

Structure
REQ-024 A shared package button_pkg SHALL hold the FSM state encodings (2 bits) and the default DEBOUNCE_CYCLES constant.
REQ-025 The synchronizer SHALL be the sub-module sync2 (ports clk, rst, d, q); the FSM and counters SHALL remain in button_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 btn_raw 0->1 held 20 cycles -> b=1 for exactly one cycle after edge 6, btn_level=1 from edge 6, press_count=1.
REQ-027 btn_raw pulses high 3 cycles, then low -> b never asserts, btn_level stays 0, press_count=0.
REQ-028 Pressed, then btn_raw drops for 2 cycles and returns high -> state returns to PRESSED, no second pulse, btn_level stays 1.
REQ-029 256 clean press/release cycles -> 256 single-cycle b pulses, press_count reads 0 at the end.
REQ-030 rst asserted for 1 cycle while in PRESSED with btn_raw held 1 -> all outputs 0 after the reset edge, then b re-fires 6 edges after rst deasserts, press_count=1.
REQ-031 DEBOUNCE_CYCLES=1, btn_raw held high -> b asserts after edge 3.
